rr_idx_arbiter: RTL and testbench

Registered round-robin arbiter that selects one of NUM_REQUESTERS level-sensitive requests and presents the winner as a one-hot grant and a binary index, held behind a valid/ready output stage. It is the sequential successor to the codebase's combinational one-hot encoding: it decides fairly among many requests, keeps the result stable under downstream stall, and supports both bit-order conventions. It sits in front of shared resources such as L2 request ports, writeback queues and thread issue, where the consumer wants an index.

---
 rtl/rr_idx_arbiter_pkg.sv | 12 +
 rtl/rr_pick.sv | 32 +++
 rtl/rr_idx_arbiter.sv | 82 ++++++++
 tb/tb_rr_idx_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rr_idx_arbiter_pkg.sv
// Shared helpers for the round-robin index arbiter.
// Holds the modulo-N successor used to seed the search.
package rr_idx_arbiter_pkg;

    function automatic int unsigned wrap_next(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-and-find-first: one-hot pick of the first set request
// at or after start, wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] pick
);

    int         p;
    logic       found;
    logic [W-1:0] pos;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        p     = 0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            p = int'(start) + k;
            if (p >= N) p = p - N;
            pos = W'(p);
            if (!found && req[pos]) begin
                pick[pos] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_idx_arbiter.sv
// Registered round-robin arbiter with one-hot and index grant
// behind a valid/ready output stage.
module rr_idx_arbiter
    import rr_idx_arbiter_pkg::*;
#(
    parameter int    NUM_REQUESTERS = 4,
    parameter string DIRECTION      = "LSB0",
    parameter int    INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    output logic [NUM_REQUESTERS-1:0] grant_oh,
    output logic [INDEX_WIDTH-1:0]    grant_idx,
    output logic                      grant_valid,
    input  logic                      grant_ready
);

    localparam int N    = NUM_REQUESTERS;
    localparam int W    = INDEX_WIDTH;
    localparam bit MSB0 = (DIRECTION == "MSB0");

    logic [N-1:0] req_log;
    logic [N-1:0] pick_log;
    logic [N-1:0] pick_phys;
    logic [W-1:0] pick_idx;
    logic [W-1:0] last_idx;
    logic [W-1:0] base;
    logic [W-1:0] start;
    logic         accept;
    logic         load;

    assign accept = grant_valid & grant_ready;
    assign load   = !grant_valid || grant_ready;

    // An acceptance this cycle seeds the search past the winner.
    assign base  = accept ? grant_idx : last_idx;
    assign start = W'(wrap_next(32'(base), N));

    always_comb begin
        req_log   = '0;
        pick_phys = '0;
        for (int i = 0; i < N; i++) begin
            req_log[i]   = MSB0 ? request[N-1-i] : request[i];
            pick_phys[i] = MSB0 ? pick_log[N-1-i] : pick_log[i];
        end
    end

    rr_pick #(
        .N(N),
        .W(W)
    ) u_pick (
        .req  (req_log),
        .start(start),
        .pick (pick_log)
    );

    // Pick is one-hot, so OR-ing the indices is an exact encode.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_log[i]) pick_idx = pick_idx | W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_valid <= 1'b0;
            grant_oh    <= '0;
            grant_idx   <= '0;
            last_idx    <= W'(N - 1);
        end else begin
            if (accept) last_idx <= grant_idx;
            if (load) begin
                grant_valid <= |req_log;
                grant_oh    <= pick_phys;
                grant_idx   <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_rr_idx_arbiter.sv
// Directed bench for rr_idx_arbiter: LSB0/MSB0 with four
// requesters and LSB0 with five requesters.
module tb_rr_idx_arbiter;

    logic       clk;
    logic       reset;

    logic [3:0] req_a, oh_a;
    logic [1:0] idx_a;
    logic       vld_a, rdy_a;

    logic [3:0] req_b, oh_b;
    logic [1:0] idx_b;
    logic       vld_b, rdy_b;

    logic [4:0] req_c, oh_c;
    logic [2:0] idx_c;
    logic       vld_c, rdy_c;

    int passed = 0;
    int total  = 0;

    rr_idx_arbiter #(
        .NUM_REQUESTERS(4),
        .DIRECTION("LSB0")
    ) dut_a (
        .clk(clk), .reset(reset), .request(req_a),
        .grant_oh(oh_a), .grant_idx(idx_a),
        .grant_valid(vld_a), .grant_ready(rdy_a)
    );

    rr_idx_arbiter #(
        .NUM_REQUESTERS(4),
        .DIRECTION("MSB0")
    ) dut_b (
        .clk(clk), .reset(reset), .request(req_b),
        .grant_oh(oh_b), .grant_idx(idx_b),
        .grant_valid(vld_b), .grant_ready(rdy_b)
    );

    rr_idx_arbiter #(
        .NUM_REQUESTERS(5),
        .DIRECTION("LSB0")
    ) dut_c (
        .clk(clk), .reset(reset), .request(req_c),
        .grant_oh(oh_c), .grant_idx(idx_c),
        .grant_valid(vld_c), .grant_ready(rdy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(
        input string tag,
        input int v,
        input int oh,
        input int idx
    );
        chk({tag, ".vld"}, 32'(vld_a), v);
        chk({tag, ".oh"},  32'(oh_a),  oh);
        chk({tag, ".idx"}, 32'(idx_a), idx);
    endtask

    int seq4[5] = '{0, 1, 2, 3, 0};
    int seq5[6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        reset = 1'b0;
        req_a = '0; rdy_a = 1'b0;
        req_b = '0; rdy_b = 1'b0;
        req_c = '0; rdy_c = 1'b0;
        #12;
        chk_a("rst_a", 0, 0, 0);
        chk("rst_b.vld", 32'(vld_b), 0);
        chk("rst_c.vld", 32'(vld_c), 0);
        chk("rst_c.idx", 32'(idx_c), 0);
        #1 reset = 1'b1;

        // LSB0 full rotation
        req_a = 4'b1111; rdy_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_a($sformatf("rot%0d", i), 1, 1 << seq4[i], seq4[i]);
        end

        // drain: accepts 0, nothing pending
        req_a = '0;
        step();
        chk_a("drain", 0, 0, 0);

        // stall on 1010
        req_a = 4'b1010; rdy_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a($sformatf("stall%0d", i), 1, 4'b0010, 1);
        end
        rdy_a = 1'b1;
        chk_a("stall3", 1, 4'b0010, 1);
        step();
        chk_a("after_acc", 1, 4'b1000, 3);

        // drop request[3] while grant 3 stalls
        rdy_a = 1'b0; req_a = 4'b0010;
        step();
        chk_a("stale0", 1, 4'b1000, 3);
        step();
        chk_a("stale1", 1, 4'b1000, 3);
        rdy_a = 1'b1;
        step();
        chk_a("post_stale", 1, 4'b0010, 1);
        req_a = '0;
        step();
        chk_a("idle", 0, 0, 0);

        // MSB0
        req_b = 4'b0001; rdy_b = 1'b1;
        step();
        chk("msb0.vld", 32'(vld_b), 1);
        chk("msb0.idx", 32'(idx_b), 3);
        chk("msb0.oh",  32'(oh_b),  4'b0001);
        req_b = 4'b1000;
        step();
        chk("msb1.idx", 32'(idx_b), 0);
        chk("msb1.oh",  32'(oh_b),  4'b1000);
        req_b = 4'b1100;
        step();
        chk("msb2.idx", 32'(idx_b), 1);
        chk("msb2.oh",  32'(oh_b),  4'b0100);

        // five requesters
        req_c = 5'b11111; rdy_c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("n5_%0d.idx", i), 32'(idx_c), seq5[i]);
            chk($sformatf("n5_%0d.oh", i), 32'(oh_c), 1 << seq5[i]);
        end

        // async reset mid-handshake; last_idx is 1 here
        req_a = 4'b1111; rdy_a = 1'b0;
        step();
        chk_a("pre_rst", 1, 4'b0100, 2);
        #2 reset = 1'b0;
        #1;
        chk_a("async_rst", 0, 0, 0);
        req_a = 4'b0110; rdy_a = 1'b1;
        #1 reset = 1'b1;
        step();
        chk_a("post_rst", 1, 4'b0010, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
